// File: rtl/move_input_ctrl.sv
// move_input_ctrl
//   Consumer end of the debounced push-button path. Detects rising edges on
//   the cleaned left/right/drop/pop buttons and keeps a wrapping cursor
//   column. It issues drop/pop commands over a valid/ready handshake and
//   locks out input until the game logic reports that the move is complete.
//
//   Optional build macro: MOVE_AUTOREPEAT_EN
//     When defined, a left or right button held in IDLE steps the cursor
//     again after REPEAT_DELAY cycles, and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   synchronous reset, active-high
//   btn_left   in   debounced left button
//   btn_right  in   debounced right button
//   btn_drop   in   debounced drop button
//   btn_pop    in   debounced pop button
//   cmd_ready  in   game logic accepts the pending command
//   move_done  in   single-cycle pulse, move finished
//   cmd_valid  out  command pending (state REQ)
//   cmd_col    out  column of the pending command
//   cmd_pop    out  1 = pop, 0 = drop
//   cursor_col out  current cursor column
//   busy       out  high whenever not IDLE
module move_input_ctrl #(
  parameter int NUM_COLS      = 7,
  parameter int COL_W         = 3,
  parameter int REPEAT_DELAY  = 300,
  parameter int REPEAT_PERIOD = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_drop,
  input  logic             btn_pop,
  input  logic             cmd_ready,
  input  logic             move_done,
  output logic             cmd_valid,
  output logic [COL_W-1:0] cmd_col,
  output logic             cmd_pop,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  if (NUM_COLS < 2 || NUM_COLS > 2**COL_W || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("move_input_ctrl: illegal parameter combination");
  end

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] CENTER_COL = COL_W'(NUM_COLS / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_n;

  logic [COL_W-1:0] cursor_n, cmd_col_n;
  logic             cmd_pop_n;

  // Edge history. These reset to 1 so that a button held through reset
  // gives no event until it has been released.
  logic left_q, right_q, drop_q, pop_q;
  logic left_e, right_e, drop_e, pop_e;

  assign left_e  = btn_left  & ~left_q;
  assign right_e = btn_right & ~right_q;
  assign drop_e  = btn_drop  & ~drop_q;
  assign pop_e   = btn_pop   & ~pop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= 1'b1;
      right_q <= 1'b1;
      drop_q  <= 1'b1;
      pop_q   <= 1'b1;
    end else begin
      left_q  <= btn_left;
      right_q <= btn_right;
      drop_q  <= btn_drop;
      pop_q   <= btn_pop;
    end
  end

  logic rpt_left, rpt_right;

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_on;
  logic             held_one;
  logic             rpt_step;

  // rpt_cnt counts the posedges since the press (or the last step). The
  // first step fires at DELAY, and each later step fires at PERIOD.
  assign held_one = btn_left ^ btn_right;
  assign rpt_step = (state == IDLE) && held_one && !(left_e || right_e) &&
                    (rpt_cnt == (rpt_on ? PERIOD_C : DELAY_C));
  assign rpt_left  = rpt_step & btn_left;
  assign rpt_right = rpt_step & btn_right;

  always_ff @(posedge clk) begin
    if (rst || state != IDLE || !held_one) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else if (left_e || right_e) begin
      rpt_cnt <= CNT_W'(1);
      rpt_on  <= 1'b0;
    end else if (rpt_step) begin
      rpt_cnt <= CNT_W'(1);
      rpt_on  <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + CNT_W'(1);
    end
  end
`else
  assign rpt_left  = 1'b0;
  assign rpt_right = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cursor_col <= CENTER_COL;
      cmd_col    <= '0;
      cmd_pop    <= 1'b0;
    end else begin
      state      <= state_n;
      cursor_col <= cursor_n;
      cmd_col    <= cmd_col_n;
      cmd_pop    <= cmd_pop_n;
    end
  end

  always_comb begin
    logic step_l, step_r;
    state_n   = state;
    cursor_n  = cursor_col;
    cmd_col_n = cmd_col;
    cmd_pop_n = cmd_pop;
    step_l    = (left_e & ~right_e) | rpt_left;
    step_r    = (right_e & ~left_e) | rpt_right;
    unique case (state)
      IDLE: begin
        if (drop_e ^ pop_e) begin
          cmd_col_n = cursor_col;
          cmd_pop_n = pop_e;
          state_n   = REQ;
        end else if (drop_e && pop_e) begin
          // Conflicting command: discard both, and move no cursor this cycle.
          state_n = IDLE;
        end else if (step_l) begin
          cursor_n = (cursor_col == '0) ? LAST_COL : cursor_col - COL_W'(1);
        end else if (step_r) begin
          cursor_n = (cursor_col == LAST_COL) ? '0 : cursor_col + COL_W'(1);
        end
      end
      REQ: begin
        if (cmd_ready) state_n = WAIT;
      end
      WAIT: begin
        if (move_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == REQ);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed self-checking bench for move_input_ctrl. Define MOVE_AUTOREPEAT_EN
// to build the design and the bench with auto-repeat (DELAY=4, PERIOD=2).
module tb_move_input_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, btn_pop = 1'b0;
  logic       cmd_ready = 1'b0, move_done = 1'b0;
  logic       cmd_valid, cmd_pop, busy;
  logic [2:0] cmd_col, cursor_col;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  move_input_ctrl #(
    .NUM_COLS(7),
    .COL_W(3),
`ifdef MOVE_AUTOREPEAT_EN
    .REPEAT_DELAY(4),
    .REPEAT_PERIOD(2)
`else
    .REPEAT_DELAY(300),
    .REPEAT_PERIOD(150)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_drop(btn_drop), .btn_pop(btn_pop),
    .cmd_ready(cmd_ready), .move_done(move_done),
    .cmd_valid(cmd_valid), .cmd_col(cmd_col), .cmd_pop(cmd_pop),
    .cursor_col(cursor_col), .busy(busy)
  );

  // Advance through one posedge, then settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();  // lets the history flops see the released buttons
  endtask

  task automatic test_reset();
    do_reset();
    if (cursor_col !== 3'd3) begin $display("FAIL reset_cursor got %0d want 3", cursor_col); n_err++; end
    n_cmp++;
    if ({cmd_valid, cmd_col, cmd_pop, busy} !== 6'b0) begin
      $display("FAIL reset_outputs got v=%b col=%0d pop=%b busy=%b want all 0", cmd_valid, cmd_col, cmd_pop, busy);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_cursor();
    logic [2:0] exp_r [4] = '{3'd4, 3'd5, 3'd6, 3'd0};
    for (int i = 0; i < 4; i++) begin
      btn_right = 1'b1; tick();
      if (cursor_col !== exp_r[i]) begin $display("FAIL right_step%0d got %0d want %0d", i, cursor_col, exp_r[i]); n_err++; end
      n_cmp++;
      btn_right = 1'b0; tick();
    end
    btn_left = 1'b1; tick();
    if (cursor_col !== 3'd6) begin $display("FAIL left_wrap got %0d want 6", cursor_col); n_err++; end
    n_cmp++;
    btn_left = 1'b0; tick();
    // walk left down to column 2
    for (int i = 0; i < 4; i++) begin
      btn_left = 1'b1; tick(); btn_left = 1'b0; tick();
    end
    if (cursor_col !== 3'd2) begin $display("FAIL left_walk got %0d want 2", cursor_col); n_err++; end
    n_cmp++;
  endtask

  task automatic test_handshake();
    int hi = 0;
    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    if ({cmd_valid, cmd_col, cmd_pop, busy} !== {1'b1, 3'd2, 1'b0, 1'b1}) begin
      $display("FAIL drop_cmd got v=%b col=%0d pop=%b busy=%b want 1 2 0 1", cmd_valid, cmd_col, cmd_pop, busy);
      n_err++;
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid) hi++;
      tick();
    end
    if (cmd_valid) hi++;
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    if (hi !== 6 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL valid_len got hi=%0d v=%b busy=%b want 6 0 1", hi, cmd_valid, busy);
      n_err++;
    end
    n_cmp++;
    tick(); tick();
    if (busy !== 1'b1) begin $display("FAIL wait_busy got %b want 1", busy); n_err++; end
    n_cmp++;
    move_done = 1'b1; tick(); move_done = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL done_idle got busy=%b want 0", busy); n_err++; end
    n_cmp++;
  endtask

  task automatic test_wait_lockout();
    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;  // now in WAIT
    btn_left = 1'b1;  tick(); btn_left = 1'b0;  tick();
    btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
    btn_drop = 1'b1;  tick(); btn_drop = 1'b0;  tick();
    if ({cursor_col, cmd_valid, busy} !== {3'd2, 1'b0, 1'b1}) begin
      $display("FAIL wait_lock got cur=%0d v=%b busy=%b want 2 0 1", cursor_col, cmd_valid, busy);
      n_err++;
    end
    n_cmp++;
    move_done = 1'b1; tick(); move_done = 1'b0;
    // cmd_ready already high: cmd_valid must last exactly one cycle
    cmd_ready = 1'b1;
    btn_pop = 1'b1; tick(); btn_pop = 1'b0;
    if ({cmd_valid, cmd_col, cmd_pop} !== {1'b1, 3'd2, 1'b1}) begin
      $display("FAIL pop_cmd got v=%b col=%0d pop=%b want 1 2 1", cmd_valid, cmd_col, cmd_pop);
      n_err++;
    end
    n_cmp++;
    tick(); cmd_ready = 1'b0;
    if ({cmd_valid, busy} !== 2'b01) begin $display("FAIL ready_early got v=%b busy=%b want 0 1", cmd_valid, busy); n_err++; end
    n_cmp++;
    move_done = 1'b1; tick(); move_done = 1'b0;
  endtask

  task automatic test_simultaneous();
    btn_drop = 1'b1; btn_pop = 1'b1; tick(); btn_drop = 1'b0; btn_pop = 1'b0;
    if ({cmd_valid, busy} !== 2'b00) begin $display("FAIL drop_pop_conflict got v=%b busy=%b want 0 0", cmd_valid, busy); n_err++; end
    n_cmp++;
    tick();
    for (int i = 0; i < 2; i++) begin
      btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
    end
    btn_drop = 1'b1; btn_right = 1'b1; tick(); btn_drop = 1'b0; btn_right = 1'b0;
    if ({cmd_valid, cmd_col, cmd_pop, cursor_col} !== {1'b1, 3'd4, 1'b0, 3'd4}) begin
      $display("FAIL drop_right got v=%b col=%0d pop=%b cur=%0d want 1 4 0 4", cmd_valid, cmd_col, cmd_pop, cursor_col);
      n_err++;
    end
    n_cmp++;
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    move_done = 1'b1; tick(); move_done = 1'b0;
    btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0;
    if (cursor_col !== 3'd4) begin $display("FAIL left_right got %0d want 4", cursor_col); n_err++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_reset_cases();
    btn_drop = 1'b1;
    do_reset();
    tick();
    if ({cmd_valid, cursor_col} !== {1'b0, 3'd3}) begin
      $display("FAIL held_through_reset got v=%b cur=%0d want 0 3", cmd_valid, cursor_col);
      n_err++;
    end
    n_cmp++;
    btn_drop = 1'b0; tick();
    btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    if ({cmd_valid, cmd_col} !== {1'b1, 3'd4}) begin
      $display("FAIL repress_cmd got v=%b col=%0d want 1 4", cmd_valid, cmd_col);
      n_err++;
    end
    n_cmp++;
    rst = 1'b1; tick();
    if ({cmd_valid, busy, cursor_col} !== {1'b0, 1'b0, 3'd3}) begin
      $display("FAIL reset_in_req got v=%b busy=%b cur=%0d want 0 0 3", cmd_valid, busy, cursor_col);
      n_err++;
    end
    n_cmp++;
    rst = 1'b0; tick();
  endtask

  task automatic test_hold();
`ifdef MOVE_AUTOREPEAT_EN
    // held from posedge N: steps at N, N+4, N+6, N+8
    logic [2:0] exp_h [10] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0};
`else
    logic [2:0] exp_h [10] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
`endif
    int bad = 0;
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cursor_col !== exp_h[i]) begin
        $display("FAIL hold_right cycle %0d got %0d want %0d", i, cursor_col, exp_h[i]);
        bad++;
      end
    end
    btn_right = 1'b0; tick();
    if (bad != 0) n_err++;
    n_cmp++;
    if (cursor_col !== exp_h[9]) begin $display("FAIL hold_release got %0d want %0d", cursor_col, exp_h[9]); n_err++; end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_handshake();
    test_wait_lockout();
    test_simultaneous();
    test_reset_cases();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
